// File: rtl/wb_flash_arbiter_pkg.sv
// Shared definitions for the flash arbiter: FSM encoding, port ids, wait-counter width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package flash_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD1  = 2'd1,
    ST_RD2  = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int WAIT_W = 4;

  // Pick the addressed byte lane of a flash word, zero-extended.
  function automatic logic [15:0] byte_lane(input logic [15:0] d, input logic odd);
    return {8'h00, (odd ? d[15:8] : d[7:0])};
  endfunction

endpackage

// File: rtl/wb_flash_arbiter_rd_seq.sv
// Single flash word read: holds NF_A with CE/OE low for WAIT_CYCLES+1 cycles, then samples NF_D.
// Latency: start edge to done pulse = WAIT_CYCLES+1 cycles; done is a registered 1-cycle pulse.
// Backpressure: none; start is only issued while idle, data holds until the next capture.
module flash_rd_seq
  import flash_arb_defs::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_nf_d,
  output logic        o_done,
  output logic [15:0] o_dat,
  output logic [15:0] o_nf_a,
  output logic        o_nf_ce,
  output logic        o_nf_oe
);

  localparam logic [WAIT_W-1:0] LP_WAIT = WAIT_W'(WAIT_CYCLES);

  logic              r_busy;
  logic [WAIT_W-1:0] r_cnt;
  logic [15:0]       r_nf_a;
  logic [15:0]       r_dat;
  logic              r_done;

  // Address latch, wait countdown and data capture when the countdown expires.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_nf_a <= '0;
      r_dat  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy <= 1'b1;
        r_cnt  <= LP_WAIT;
        r_nf_a <= i_addr;
      end else if (r_busy) begin
        if (r_cnt == '0) begin
          r_busy <= 1'b0;
          r_dat  <= i_nf_d;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign o_done  = r_done;
  assign o_dat   = r_dat;
  assign o_nf_a  = r_nf_a;
  assign o_nf_ce = ~r_busy;
  assign o_nf_oe = ~r_busy;

endmodule

// File: rtl/wb_flash_arbiter.sv
// Two-port round-robin Wishbone read arbiter for 16-bit NOR flash; FLASH_ARB_MISALIGN_EN enables split odd-word reads.
// Latency: stb sample to ack = WAIT_CYCLES+2 (aligned/byte), 2*WAIT_CYCLES+4 (split odd word).
// Backpressure: requester holds stb until its 1-cycle ack; a port is masked for the cycle after its ack.
module wb_flash_arbiter
  import flash_arb_defs::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        m0_stb_i,
  input  logic [16:0] m0_adr_i,
  input  logic        m0_byte_i,
  output logic [15:0] m0_dat_o,
  output logic        m0_ack_o,
  input  logic        m1_stb_i,
  input  logic [16:0] m1_adr_i,
  input  logic        m1_byte_i,
  output logic [15:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic [21:1] NF_A,
  input  logic [15:0] NF_D,
  output logic        NF_CE,
  output logic        NF_OE,
  output logic        NF_WE,
  output logic        NF_BYTE
);

  state_t      r_state, w_next;
  logic        r_port, r_last, r_byte;
  logic [16:0] r_adr;
  logic        r_m0_ack, r_m1_ack, r_hold0, r_hold1;
  logic [15:0] r_m0_dat, r_m1_dat;

  logic        w_req0, w_req1, w_gnt;
  logic [16:0] w_gnt_adr;
  logic        w_gnt_byte;
  logic        w_start, w_to_ack, w_split;
  logic [15:0] w_seq_adr, w_seq_dat, w_seq_a, w_asm;
  logic        w_seq_done;

`ifdef FLASH_ARB_MISALIGN_EN
  logic [15:0] r_d1;
  assign w_split = ~r_byte & r_adr[0];
`else
  assign w_split = 1'b0;
`endif

  // A port that was just acked sits out one IDLE cycle so a held strobe is not re-served at once.
  assign w_req0     = m0_stb_i & ~r_hold0;
  assign w_req1     = m1_stb_i & ~r_hold1;
  assign w_gnt      = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_gnt_adr  = w_gnt ? m1_adr_i : m0_adr_i;
  assign w_gnt_byte = w_gnt ? m1_byte_i : m0_byte_i;

  // Data assembly from the word just captured (and the first word of a split read).
  always_comb begin
    w_asm = w_seq_dat;
    if (r_byte) begin
      w_asm = byte_lane(w_seq_dat, r_adr[0]);
    end
`ifdef FLASH_ARB_MISALIGN_EN
    else if (w_split) begin
      w_asm = {w_seq_dat[7:0], r_d1[15:8]};
    end
`endif
  end

  // Next-state logic and sequencer start requests.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_seq_adr = '0;
    w_to_ack  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 | w_req1) begin
          w_next    = ST_RD1;
          w_start   = 1'b1;
          w_seq_adr = w_gnt_adr[16:1];
        end
      end
      ST_RD1: begin
        if (w_seq_done) begin
          if (w_split) begin
            w_next    = ST_RD2;
            w_start   = 1'b1;
            w_seq_adr = r_adr[16:1] + 16'd1;
          end else begin
            w_next   = ST_ACK;
            w_to_ack = 1'b1;
          end
        end
      end
`ifdef FLASH_ARB_MISALIGN_EN
      ST_RD2: begin
        if (w_seq_done) begin
          w_next   = ST_ACK;
          w_to_ack = 1'b1;
        end
      end
`endif
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, grant bookkeeping, per-port ack pulse and data hold registers.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state  <= ST_IDLE;
      r_port   <= PORT0;
      r_last   <= PORT1;
      r_adr    <= '0;
      r_byte   <= 1'b0;
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      r_hold0  <= 1'b0;
      r_hold1  <= 1'b0;
      r_m0_dat <= '0;
      r_m1_dat <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_start) begin
        r_port <= w_gnt;
        r_last <= w_gnt;
        r_adr  <= w_gnt_adr;
        r_byte <= w_gnt_byte;
      end
      r_m0_ack <= w_to_ack & (r_port == PORT0);
      r_m1_ack <= w_to_ack & (r_port == PORT1);
      r_hold0  <= r_m0_ack;
      r_hold1  <= r_m1_ack;
      if (w_to_ack && r_port == PORT0) r_m0_dat <= w_asm;
      if (w_to_ack && r_port == PORT1) r_m1_dat <= w_asm;
    end
  end

`ifdef FLASH_ARB_MISALIGN_EN
  // First half of a split read, kept while the second word is fetched.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_d1 <= '0;
    end else if (r_state == ST_RD1 && w_seq_done) begin
      r_d1 <= w_seq_dat;
    end
  end
`endif

  flash_rd_seq #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_rd_seq (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_start (w_start),
    .i_addr  (w_seq_adr),
    .i_nf_d  (NF_D),
    .o_done  (w_seq_done),
    .o_dat   (w_seq_dat),
    .o_nf_a  (w_seq_a),
    .o_nf_ce (NF_CE),
    .o_nf_oe (NF_OE)
  );

  assign NF_A     = {5'b0, w_seq_a};
  assign NF_WE    = 1'b1;
  assign NF_BYTE  = 1'b1;
  assign m0_ack_o = r_m0_ack;
  assign m1_ack_o = r_m1_ack;
  assign m0_dat_o = r_m0_dat;
  assign m1_dat_o = r_m1_dat;

endmodule

// File: tb/tb_wb_flash_arbiter.sv
// Directed bench for wb_flash_arbiter with a combinational flash model.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_flash_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_stb, m0_byte, m0_ack, m1_stb, m1_byte, m1_ack;
  logic [16:0] m0_adr, m1_adr;
  logic [15:0] m0_dat, m1_dat, nf_d;
  logic [21:1] nf_a;
  logic        nf_ce, nf_oe, nf_we, nf_byte;
  logic [15:0] flash [0:65535];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign nf_d = flash[nf_a[16:1]];

  wb_flash_arbiter #(.WAIT_CYCLES(2)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_stb_i(m0_stb), .m0_adr_i(m0_adr), .m0_byte_i(m0_byte), .m0_dat_o(m0_dat), .m0_ack_o(m0_ack),
    .m1_stb_i(m1_stb), .m1_adr_i(m1_adr), .m1_byte_i(m1_byte), .m1_dat_o(m1_dat), .m1_ack_o(m1_ack),
    .NF_A(nf_a), .NF_D(nf_d), .NF_CE(nf_ce), .NF_OE(nf_oe), .NF_WE(nf_we), .NF_BYTE(nf_byte)
  );

  // Issue one read on a port and observe it until ack (bounded); lat = -1 on timeout.
  task automatic run_read(input int port, input logic [16:0] adr, input logic byt,
                          output int lat, output logic [15:0] dat, output int ce_cyc,
                          output logic [21:1] a_first, output logic [21:1] a_last,
                          output bit other_ack);
    int cnt;
    bit got;
    @(negedge clk);
    if (port == 0) begin m0_stb = 1'b1; m0_adr = adr; m0_byte = byt; end
    else           begin m1_stb = 1'b1; m1_adr = adr; m1_byte = byt; end
    cnt = 0; got = 0; ce_cyc = 0; other_ack = 0;
    a_first = '0; a_last = '0; dat = '0; lat = -1;
    while (!got && cnt < 60) begin
      @(posedge clk); @(negedge clk);
      cnt++;
      if (!nf_ce) begin
        if (ce_cyc == 0) a_first = nf_a;
        a_last = nf_a;
        ce_cyc++;
      end
      if ((port == 0) ? m1_ack : m0_ack) other_ack = 1;
      if ((port == 0) ? m0_ack : m1_ack) begin
        got = 1;
        lat = cnt - 1;
        dat = (port == 0) ? m0_dat : m1_dat;
      end
    end
    m0_stb = 1'b0;
    m1_stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int cnt;
    bit got;
    rst_n = 1'b0; m0_stb = 1'b1; m0_adr = 17'h00010; m0_byte = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (m0_ack !== 1'b0) begin bad++; $display("FAIL rst_m0_ack: got %b expected 0", m0_ack); end
    total++; if (m1_ack !== 1'b0) begin bad++; $display("FAIL rst_m1_ack: got %b expected 0", m1_ack); end
    total++; if (nf_ce !== 1'b1 || nf_oe !== 1'b1) begin bad++; $display("FAIL rst_ce_oe: got %b%b expected 11", nf_ce, nf_oe); end
    total++; if (m0_dat !== 16'h0000 || m1_dat !== 16'h0000) begin bad++; $display("FAIL rst_dat: got %h/%h expected 0000/0000", m0_dat, m1_dat); end
    total++; if (nf_a !== 21'h0) begin bad++; $display("FAIL rst_nf_a: got %h expected 0", nf_a); end
    total++; if (nf_we !== 1'b1 || nf_byte !== 1'b1) begin bad++; $display("FAIL rst_we_byte: got %b%b expected 11", nf_we, nf_byte); end
    rst_n = 1'b1;
    cnt = 0; got = 0;
    while (!got && cnt < 60) begin
      @(posedge clk); @(negedge clk);
      cnt++;
      if (m0_ack) got = 1;
    end
    total++; if (cnt - 1 !== 4 || !got) begin bad++; $display("FAIL rst_first_lat: got %0d expected 4", got ? cnt - 1 : -1); end
    total++; if (m0_dat !== 16'hA55A) begin bad++; $display("FAIL rst_first_dat: got %h expected a55a", m0_dat); end
    m0_stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_word_read();
    int lat, ce; logic [15:0] d; logic [21:1] a1, a2; bit oth;
    run_read(0, 17'h00010, 1'b0, lat, d, ce, a1, a2, oth);
    total++; if (d !== 16'hA55A) begin bad++; $display("FAIL word_dat: got %h expected a55a", d); end
    total++; if (lat !== 4) begin bad++; $display("FAIL word_lat: got %0d expected 4", lat); end
    total++; if (a1 !== 21'h8 || a2 !== 21'h8) begin bad++; $display("FAIL word_nf_a: got %h/%h expected 8/8", a1, a2); end
    total++; if (ce !== 3) begin bad++; $display("FAIL word_ce_cycles: got %0d expected 3", ce); end
    total++; if (oth !== 1'b0) begin bad++; $display("FAIL word_other_ack: got %b expected 0", oth); end
  endtask

  task automatic test_byte_read();
    int lat, ce; logic [15:0] d; logic [21:1] a1, a2; bit oth;
    run_read(1, 17'h00011, 1'b1, lat, d, ce, a1, a2, oth);
    total++; if (d !== 16'h00A5) begin bad++; $display("FAIL byte_hi_dat: got %h expected 00a5", d); end
    total++; if (lat !== 4) begin bad++; $display("FAIL byte_hi_lat: got %0d expected 4", lat); end
    total++; if (oth !== 1'b0) begin bad++; $display("FAIL byte_other_ack: got %b expected 0", oth); end
    total++; if (m0_dat !== 16'hA55A) begin bad++; $display("FAIL byte_m0_hold: got %h expected a55a", m0_dat); end
    run_read(1, 17'h00010, 1'b1, lat, d, ce, a1, a2, oth);
    total++; if (d !== 16'h005A) begin bad++; $display("FAIL byte_lo_dat: got %h expected 005a", d); end
    run_read(0, 17'h1FFFF, 1'b1, lat, d, ce, a1, a2, oth);
    total++; if (d !== 16'h0012 || lat !== 4) begin bad++; $display("FAIL byte_top_dat_lat: got %h/%0d expected 0012/4", d, lat); end
  endtask

  task automatic test_odd_word();
    int lat, ce; logic [15:0] d; logic [21:1] a1, a2; bit oth;
    run_read(0, 17'h1FFFF, 1'b0, lat, d, ce, a1, a2, oth);
`ifdef FLASH_ARB_MISALIGN_EN
    total++; if (d !== 16'h3412) begin bad++; $display("FAIL odd_dat: got %h expected 3412", d); end
    total++; if (lat !== 8) begin bad++; $display("FAIL odd_lat: got %0d expected 8", lat); end
    total++; if (a1 !== 21'h0FFFF || a2 !== 21'h0) begin bad++; $display("FAIL odd_nf_a_seq: got %h/%h expected ffff/0", a1, a2); end
    total++; if (ce !== 6) begin bad++; $display("FAIL odd_ce_cycles: got %0d expected 6", ce); end
`else
    total++; if (d !== 16'h12AB) begin bad++; $display("FAIL odd_dat: got %h expected 12ab", d); end
    total++; if (lat !== 4) begin bad++; $display("FAIL odd_lat: got %0d expected 4", lat); end
    total++; if (a1 !== 21'h0FFFF || a2 !== 21'h0FFFF) begin bad++; $display("FAIL odd_nf_a_seq: got %h/%h expected ffff/ffff", a1, a2); end
    total++; if (ce !== 3) begin bad++; $display("FAIL odd_ce_cycles: got %0d expected 3", ce); end
`endif
    total++; if (m1_dat !== 16'h005A) begin bad++; $display("FAIL odd_m1_hold: got %h expected 005a", m1_dat); end
  endtask

  task automatic test_back_to_back();
    int cyc, n;
    int order [4];
    int when [4];
    bit both;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m0_stb = 1'b1; m0_adr = 17'h00010; m0_byte = 1'b0;
    m1_stb = 1'b1; m1_adr = 17'h00020; m1_byte = 1'b0;
    cyc = 0; n = 0; both = 0;
    while (n < 4 && cyc < 100) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (m0_ack && m1_ack) both = 1;
      if (m0_ack || m1_ack) begin
        order[n] = m1_ack ? 1 : 0;
        when[n]  = cyc;
        total++;
        if ((m1_ack ? m1_dat : m0_dat) !== (m1_ack ? 16'h1234 : 16'hA55A)) begin
          bad++; $display("FAIL b2b_dat%0d: got %h expected %h", n, m1_ack ? m1_dat : m0_dat, m1_ack ? 16'h1234 : 16'hA55A);
        end
        n++;
      end
    end
    m0_stb = 1'b0; m1_stb = 1'b0;
    total++; if (n !== 4) begin bad++; $display("FAIL b2b_count: got %0d expected 4", n); end
    total++; if (both) begin bad++; $display("FAIL b2b_dual_ack: got 1 expected 0"); end
    if (n == 4) begin
      total++; if (when[0] - 1 !== 4) begin bad++; $display("FAIL b2b_first_lat: got %0d expected 4", when[0] - 1); end
      for (int i = 0; i < 4; i++) begin
        total++; if (order[i] !== (i % 2)) begin bad++; $display("FAIL b2b_order%0d: got %0d expected %0d", i, order[i], i % 2); end
      end
      for (int i = 1; i < 4; i++) begin
        total++; if (when[i] - when[i-1] !== 6) begin bad++; $display("FAIL b2b_spacing%0d: got %0d expected 6", i, when[i] - when[i-1]); end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_rd();
    int cnt;
    bit got;
    @(negedge clk);
    m1_stb = 1'b1; m1_adr = 17'h00020; m1_byte = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (nf_ce !== 1'b0) begin bad++; $display("FAIL midrst_in_rd1: got ce=%b expected 0", nf_ce); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    total++; if (nf_ce !== 1'b1 || nf_oe !== 1'b1) begin bad++; $display("FAIL midrst_ce_oe: got %b%b expected 11", nf_ce, nf_oe); end
    total++; if (m1_ack !== 1'b0 || m1_dat !== 16'h0000) begin bad++; $display("FAIL midrst_ack_dat: got %b/%h expected 0/0000", m1_ack, m1_dat); end
    rst_n = 1'b1;
    cnt = 0; got = 0;
    while (!got && cnt < 60) begin
      @(posedge clk); @(negedge clk);
      cnt++;
      if (m1_ack) got = 1;
    end
    total++; if (!got || cnt - 1 !== 4) begin bad++; $display("FAIL midrst_reservice_lat: got %0d expected 4", got ? cnt - 1 : -1); end
    total++; if (m1_dat !== 16'h1234) begin bad++; $display("FAIL midrst_reservice_dat: got %h expected 1234", m1_dat); end
    m1_stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    m0_stb = 1'b0; m0_adr = '0; m0_byte = 1'b0;
    m1_stb = 1'b0; m1_adr = '0; m1_byte = 1'b0;
    for (int i = 0; i < 65536; i++) flash[i] = 16'h0000;
    flash[16'h0008] = 16'hA55A;
    flash[16'h0010] = 16'h1234;
    flash[16'hFFFF] = 16'h12AB;
    flash[16'h0000] = 16'hCD34;
    test_reset();
    test_word_read();
    test_byte_read();
    test_odd_word();
    test_back_to_back();
    test_reset_mid_rd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
